// File: rtl/gcd_ctrl_fsm.sv
// Control FSM for a subtract-and-swap GCD datapath with start/done handshake.
// Optional iteration limit enabled by defining GCD_TIMEOUT_EN.
module gcd_ctrl_fsm #(
    parameter int WID      = 8,
    parameter int CNT_WID  = 2 * WID,
    parameter int MAX_ITER = 2 ** (2 * WID) - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               a_eq_b,
    input  logic               a_lt_b,
    input  logic               a_zero,
    input  logic               b_zero,
    output logic               sel_A,
    output logic               sel_B,
    output logic               ld_A,
    output logic               ld_B,
    output logic               busy,
    output logic               done,
    output logic               out_sel,
    output logic [CNT_WID-1:0] iter_cnt,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CMP   = 3'd2,
        SUB_A = 3'd3,
        SUB_B = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               sel_a_q, sel_a_d;
    logic               sel_b_q, sel_b_d;
    logic               ld_a_q, ld_a_d;
    logic               ld_b_q, ld_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               out_sel_q, out_sel_d;
    logic [CNT_WID-1:0] iter_cnt_q, iter_cnt_d;
    logic               err_q, err_d;

`ifdef GCD_TIMEOUT_EN
    localparam logic [CNT_WID-1:0] ITER_LIMIT = CNT_WID'(MAX_ITER);
`endif

    // Next state plus result bookkeeping; outputs are decoded from the next
    // state so their registers line up with the state register.
    always_comb begin
        state_d    = state_q;
        out_sel_d  = out_sel_q;
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    out_sel_d  = 1'b0;
                    iter_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            LOAD: state_d = CMP;
            CMP: begin
                if (a_zero && b_zero) begin
                    state_d   = DONE;
                    out_sel_d = 1'b0;
                end else if (a_zero) begin
                    state_d   = DONE;
                    out_sel_d = 1'b1;
                end else if (b_zero || a_eq_b) begin
                    state_d   = DONE;
                    out_sel_d = 1'b0;
`ifdef GCD_TIMEOUT_EN
                end else if (iter_cnt_q == ITER_LIMIT) begin
                    state_d   = DONE;
                    out_sel_d = 1'b0;
                    err_d     = 1'b1;
`endif
                end else if (a_lt_b) begin
                    state_d = SUB_B;
                end else begin
                    state_d = SUB_A;
                end
            end
            SUB_A, SUB_B: begin
                state_d = CMP;
                if (iter_cnt_q != '1) begin
                    iter_cnt_d = iter_cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ld_a_d  = (state_d == LOAD) || (state_d == SUB_A);
        ld_b_d  = (state_d == LOAD) || (state_d == SUB_B);
        sel_a_d = (state_d == SUB_A);
        sel_b_d = (state_d == SUB_B);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_a_q    <= 1'b0;
            sel_b_q    <= 1'b0;
            ld_a_q     <= 1'b0;
            ld_b_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_sel_q  <= 1'b0;
            iter_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            ld_a_q     <= ld_a_d;
            ld_b_q     <= ld_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_sel_q  <= out_sel_d;
            iter_cnt_q <= iter_cnt_d;
            err_q      <= err_d;
        end
    end

    assign sel_A    = sel_a_q;
    assign sel_B    = sel_b_q;
    assign ld_A     = ld_a_q;
    assign ld_B     = ld_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign out_sel  = out_sel_q;
    assign iter_cnt = iter_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_gcd_ctrl_fsm.sv
// Self-checking bench: closes an A/B register + subtractor model around the FSM
// and compares each run against an arithmetic GCD reference.
module tb_gcd_ctrl_fsm;

    localparam int WID      = 8;
    localparam int CNT_WID  = 16;
    localparam int MAX_ITER = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               a_eq_b, a_lt_b, a_zero, b_zero;
    logic               sel_A, sel_B, ld_A, ld_B, busy, done, out_sel, err;
    logic [CNT_WID-1:0] iter_cnt;

    logic [WID-1:0] a_reg, b_reg, ext_a, ext_b;

    int checks = 0;
    int errors = 0;

    gcd_ctrl_fsm #(.WID(WID), .CNT_WID(CNT_WID), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .a_zero(a_zero), .b_zero(b_zero),
        .sel_A(sel_A), .sel_B(sel_B), .ld_A(ld_A), .ld_B(ld_B),
        .busy(busy), .done(done), .out_sel(out_sel), .iter_cnt(iter_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Datapath model: operand registers with their muxes and subtractors
    always @(posedge clk) begin
        if (ld_A) a_reg <= sel_A ? (a_reg - b_reg) : ext_a;
        if (ld_B) b_reg <= sel_B ? (b_reg - a_reg) : ext_b;
    end

    assign a_eq_b = (a_reg == b_reg);
    assign a_lt_b = (a_reg < b_reg);
    assign a_zero = (a_reg == '0);
    assign b_zero = (b_reg == '0);

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: Euclid by repeated subtraction, with the optional step limit
    task automatic gcdRef(input int a, input int b, output int result, output int steps,
                          output int osel, output int timeout);
        steps = 0; osel = 0; timeout = 0; result = 0;
        if (a == 0 && b == 0) result = 0;
        else if (a == 0) begin result = b; osel = 1; end
        else if (b == 0) result = a;
        else begin
            while (a != b) begin
`ifdef GCD_TIMEOUT_EN
                if (steps == MAX_ITER) begin timeout = 1; break; end
`endif
                if (a < b) b = b - a; else a = a - b;
                steps++;
            end
            result = a;
        end
    endtask

    // One operation: start sampled at edge t, k counts cycles after t.
    // pulse_at/rst_at give the edge (relative to t) at which an extra start
    // or a reset is sampled; 0 disables.
    task automatic applyStimulus(input string tag, input int a, input int b,
                                 input int pulse_at, input int rst_at);
        int exp_res, exp_steps, exp_osel, exp_to, exp_lat, k, got_lat;
        bit busy_ok;
        gcdRef(a, b, exp_res, exp_steps, exp_osel, exp_to);
        exp_lat = 3 + 2 * (exp_to ? MAX_ITER : exp_steps);
        ext_a = WID'(a);
        ext_b = WID'(b);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        got_lat = -1;
        busy_ok = 1'b1;
        while (k <= 1200) begin
            if (rst_at != 0 && k == rst_at) begin
                checkOutput({tag, ".rst_busy"}, int'(busy), 0);
                checkOutput({tag, ".rst_iter"}, int'(iter_cnt), 0);
                checkOutput({tag, ".rst_ld"}, int'({ld_A, ld_B, sel_A, sel_B, done}), 0);
                rst = 1'b0;
                return;
            end
            if (!busy) busy_ok = 1'b0;
            start = (pulse_at != 0 && k == pulse_at - 1);
            if (rst_at != 0 && k == rst_at - 1) rst = 1'b1;
            if (done) begin
                got_lat = k;
                break;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        checkOutput({tag, ".latency"}, got_lat, exp_lat);
        checkOutput({tag, ".busy_run"}, int'(busy_ok), 1);
        if (got_lat < 0) return;
        checkOutput({tag, ".err"}, int'(err), exp_to);
        checkOutput({tag, ".out_sel"}, int'(out_sel), exp_osel);
        checkOutput({tag, ".iter"}, int'(iter_cnt), exp_to ? MAX_ITER : exp_steps);
        if (!exp_to)
            checkOutput({tag, ".result"}, int'(out_sel ? b_reg : a_reg), exp_res);
        @(negedge clk);
        checkOutput({tag, ".idle_after"}, int'({busy, done}), 0);
        checkOutput({tag, ".iter_hold"}, int'(iter_cnt), exp_to ? MAX_ITER : exp_steps);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        ext_a = '0;
        ext_b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.ctrl", int'({sel_A, sel_B, ld_A, ld_B, busy, done, out_sel, err}), 0);
        checkOutput("reset.iter", int'(iter_cnt), 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle.busy", int'(busy), 0);
        checkOutput("idle.ld", int'({ld_A, ld_B}), 0);

        applyStimulus("g48_18", 48, 18, 0, 0);
        applyStimulus("g7_7", 7, 7, 0, 0);
        applyStimulus("g0_5", 0, 5, 0, 0);
        applyStimulus("g0_0", 0, 0, 0, 0);
        applyStimulus("g5_0", 5, 0, 0, 0);
        applyStimulus("g48_18_pulse", 48, 18, 4, 0);
        applyStimulus("g48_18_rst", 48, 18, 0, 5);
        @(negedge clk);
        applyStimulus("g48_18_after", 48, 18, 0, 0);
        applyStimulus("g1_255", 1, 255, 0, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
